// File: rtl/fp_add_norm_round.sv
`timescale 1ns/1ps
// FP32 adder back end: normalize {carry,sum}, round per RISC-V rm, pack result + {NV,DZ,OF,UF,NX}.
// Latency: k NORM cycles + 1 ROUND cycle; FP_NORM_LZC_EN makes k=1 via a leading-zero count.
// Backpressure: accepts only in IDLE; result/flags held in DONE until out_ready, no same-cycle re-accept.
module fp_add_norm_round #(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] mantissa_sum,
  input  logic        carry,
  input  logic        sign_res,
  input  logic        sticky_bit,
  input  logic        eff_sub,
  input  logic [7:0]  exp_in,
  input  logic [2:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  flags
);
  localparam logic [2:0] RNE = 3'b000;
  localparam logic [2:0] RDN = 3'b010;
  localparam logic [2:0] RUP = 3'b011;
  localparam logic [2:0] RMM = 3'b100;
  localparam logic signed [9:0] STEP_E = 10'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
  state_t state;

  logic [48:0]       man;
  logic signed [9:0] exp_r;
  logic              sticky, sign_r, eff_sub_r, zero_r;
  logic [2:0]        rm_r;

  logic              g, r, s, lsb, inexact, inc, tiny, ovf, to_inf;
  logic [24:0]       mant_rnd;
  logic [23:0]       mant_fin;
  logic signed [9:0] exp_fin;
  logic [31:0]       res_c;
  logic [4:0]        flg_c;

  always_comb begin
    g       = man[23];
    r       = man[22];
    s       = (|man[21:0]) | sticky;
    lsb     = man[24];
    inexact = g | r | s;
    case (rm_r)
      RNE:     inc = g & (r | s | lsb);
      RDN:     inc = inexact & sign_r;
      RUP:     inc = inexact & ~sign_r;
      RMM:     inc = g;
      default: inc = 1'b0;
    endcase
    // A carry out of the 24-bit significand renormalizes to exactly 1.0 at the next exponent.
    mant_rnd = {1'b0, man[47:24]} + {24'd0, inc};
    mant_fin = mant_rnd[24] ? 24'h800000 : mant_rnd[23:0];
    exp_fin  = mant_rnd[24] ? exp_r + 10'sd1 : exp_r;
    tiny     = ~mant_fin[23];
    ovf      = exp_fin >= 10'sd255;
    to_inf   = (rm_r == RNE) || (rm_r == RMM) || (rm_r == RUP && !sign_r) || (rm_r == RDN && sign_r);
    if (zero_r) begin
      res_c = {eff_sub_r ? (rm_r == RDN) : sign_r, 31'd0};
      flg_c = 5'b00000;
    end else if (ovf) begin
      res_c = to_inf ? {sign_r, 8'hFF, 23'd0} : {sign_r, 8'hFE, 23'h7FFFFF};
      flg_c = 5'b00101;
    end else begin
      res_c = {sign_r, tiny ? 8'd0 : exp_fin[7:0], mant_fin[22:0]};
      flg_c = {3'b000, tiny & inexact, inexact};
    end
  end

`ifdef FP_NORM_LZC_EN
  logic signed [9:0] lzc, lz_lim, lz_shamt;
  always_comb begin
    lzc = 10'sd48;
    for (int i = 0; i < 48; i++) begin
      if (man[i]) lzc = 10'(47 - i);
    end
    // Never shift below exponent 1: the remainder stays subnormal.
    lz_lim   = (exp_r > 10'sd1) ? exp_r - 10'sd1 : 10'sd0;
    lz_shamt = (lz_lim < lzc) ? lz_lim : lzc;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= 32'd0;
      flags     <= 5'd0;
      man       <= 49'd0;
      exp_r     <= 10'sd0;
      sticky    <= 1'b0;
      sign_r    <= 1'b0;
      eff_sub_r <= 1'b0;
      zero_r    <= 1'b0;
      rm_r      <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            man       <= {carry, mantissa_sum};
            exp_r     <= signed'({2'b00, exp_in});
            sticky    <= sticky_bit;
            sign_r    <= sign_res;
            eff_sub_r <= eff_sub;
            rm_r      <= rm;
            zero_r    <= 1'b0;
            in_ready  <= 1'b0;
            state     <= NORM;
          end
        end
        NORM: begin
          if (!man[48] && man[47:0] == 48'd0 && !sticky) begin
            zero_r <= 1'b1;
            state  <= ROUND;
          end else if (man[48]) begin
            man    <= man >> 1;
            sticky <= sticky | man[0];
            exp_r  <= exp_r + 10'sd1;
            state  <= ROUND;
          end
`ifdef FP_NORM_LZC_EN
          else begin
            man   <= man << lz_shamt;
            exp_r <= exp_r - lz_shamt;
            state <= ROUND;
          end
`else
          else if (man[47 -: SHIFT_STEP] == '0 && exp_r > STEP_E) begin
            man   <= man << SHIFT_STEP;
            exp_r <= exp_r - STEP_E;
          end else if (!man[47] && exp_r > 10'sd1) begin
            man   <= man << 1;
            exp_r <= exp_r - 10'sd1;
          end else begin
            state <= ROUND;
          end
`endif
        end
        ROUND: begin
          result    <= res_c;
          flags     <= flg_c;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_norm_round.sv
`timescale 1ns/1ps
// Directed-vector bench for fp_add_norm_round: result, flags, latency, backpressure and reset.
module tb_fp_add_norm_round;
  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] mantissa_sum;
  logic        carry;
  logic        sign_res;
  logic        sticky_bit;
  logic        eff_sub;
  logic [7:0]  exp_in;
  logic [2:0]  rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  flags;

  int checks = 0;
  int errors = 0;

`ifdef FP_NORM_LZC_EN
  localparam int CANCEL_LAT = 2;
`else
  localparam int CANCEL_LAT = 6;
`endif

  fp_add_norm_round #(.SHIFT_STEP(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mantissa_sum(mantissa_sum), .carry(carry), .sign_res(sign_res),
    .sticky_bit(sticky_bit), .eff_sub(eff_sub), .exp_in(exp_in), .rm(rm),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic c, input logic [47:0] sum, input logic sg, input logic st,
                       input logic es, input logic [7:0] e, input logic [2:0] m);
    carry = c; mantissa_sum = sum; sign_res = sg; sticky_bit = st;
    eff_sub = es; exp_in = e; rm = m;
  endtask

  task automatic op(input string tag, input logic c, input logic [47:0] sum, input logic sg,
                    input logic st, input logic es, input logic [7:0] e, input logic [2:0] m,
                    input logic [31:0] exp_res, input logic [4:0] exp_flg, input int exp_lat,
                    input int hold);
    int lat;
    @(negedge clk);
    check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    drive(c, sum, sg, st, es, e, m);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    @(negedge clk);
    check({tag, " result"}, result, exp_res);
    check({tag, " flags"}, 32'(flags), 32'(exp_flg));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " held result"}, result, exp_res);
      check({tag, " held flags"}, 32'(flags), 32'(exp_flg));
      check({tag, " held out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " held in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(1'b0, 48'd0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset flags", 32'(flags), 32'd0);

    // carry, sum, sign, sticky, eff_sub, exp, rm, result, flags, latency, hold
    op("one_plus_one", 1'b1, 48'd0, 1'b0, 1'b0, 1'b0, 8'd127, 3'b000, 32'h40000000, 5'h00, 2, 0);
    op("cancel", 1'b0, 48'h0100_0000_0000, 1'b0, 1'b0, 1'b1, 8'd127, 3'b000, 32'h3C000000, 5'h00, CANCEL_LAT, 0);
    op("zero_rne", 1'b0, 48'd0, 1'b0, 1'b0, 1'b1, 8'd100, 3'b000, 32'h00000000, 5'h00, 2, 0);
    op("zero_rdn", 1'b0, 48'd0, 1'b0, 1'b0, 1'b1, 8'd100, 3'b010, 32'h80000000, 5'h00, 2, 0);
    op("ovf_rne", 1'b1, 48'd0, 1'b0, 1'b0, 1'b0, 8'd254, 3'b000, 32'h7F800000, 5'h05, 2, 0);
    op("ovf_rtz", 1'b1, 48'd0, 1'b0, 1'b0, 1'b0, 8'd254, 3'b001, 32'h7F7FFFFF, 5'h05, 2, 0);
    op("tie_rne", 1'b0, 48'h8000_0080_0000, 1'b0, 1'b0, 1'b0, 8'd127, 3'b000, 32'h3F800000, 5'h01, 2, 0);
    op("tie_rup", 1'b0, 48'h8000_0080_0000, 1'b0, 1'b0, 1'b0, 8'd127, 3'b011, 32'h3F800001, 5'h01, 2, 0);
    op("tie_rmm", 1'b0, 48'h8000_0080_0000, 1'b0, 1'b0, 1'b0, 8'd127, 3'b100, 32'h3F800001, 5'h01, 2, 0);
    op("rnd_carry", 1'b0, 48'hFFFF_FF80_0000, 1'b0, 1'b0, 1'b0, 8'd127, 3'b000, 32'h40000000, 5'h01, 2, 0);
    op("rdn_neg", 1'b0, 48'h8000_0040_0000, 1'b1, 1'b0, 1'b0, 8'd127, 3'b010, 32'hBF800001, 5'h01, 2, 0);
    op("subn_exact", 1'b0, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 8'd1, 3'b000, 32'h00400000, 5'h00, 2, 0);
    op("subn_uf_rne", 1'b0, 48'h4000_0000_0000, 1'b0, 1'b1, 1'b0, 8'd1, 3'b000, 32'h00400000, 5'h03, 2, 0);
    op("subn_uf_rup", 1'b0, 48'h4000_0000_0000, 1'b0, 1'b1, 1'b0, 8'd1, 3'b011, 32'h00400001, 5'h03, 2, 0);
    op("backpressure", 1'b1, 48'd0, 1'b0, 1'b0, 1'b0, 8'd127, 3'b000, 32'h40000000, 5'h00, 2, 5);

    // Reset while the cancellation bundle is in NORM.
    @(negedge clk);
    drive(1'b0, 48'h0100_0000_0000, 1'b0, 1'b0, 1'b1, 8'd127, 3'b000);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset in_ready", 32'(in_ready), 32'd1);
    check("midreset out_valid", 32'(out_valid), 32'd0);
    repeat (8) @(posedge clk);
    #1 check("midreset discarded", 32'(out_valid), 32'd0);

    op("after_reset", 1'b1, 48'd0, 1'b1, 1'b0, 1'b0, 8'd127, 3'b000, 32'hC0000000, 5'h00, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_add_norm_round.md
Name: fp_add_norm_round

Overview:
- Back-end stage of the FP32 adder. It consumes the raw 48-bit mantissa sum, carry, sign and sticky bit from the mantissa add/sub stage, together with the common (larger) exponent.
- It normalizes the sum iteratively, rounds per the RISC-V rounding mode, and packs the IEEE-754 single-precision result with exception flags.
- Valid/ready on both sides. Sits between the mantissa adder and the FPU writeback mux.

Parameters:
- SHIFT_STEP, 4, left-shift distance used per NORM cycle when the top SHIFT_STEP bits are all zero.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  operand bundle valid
- in_ready  out  1  stage can accept (high only in IDLE)
- mantissa_sum  in  48  sum; bit47 = hidden-bit position, 46:24 fraction, 23 guard, 22 round, 21:0 sticky source
- carry  in  1  sum overflowed into bit48
- sign_res  in  1  sign from adder
- sticky_bit  in  1  sticky from alignment/adder
- eff_sub  in  1  effective subtraction (sign1^sign2)
- exp_in  in  8  biased common exponent; subnormal operands pre-mapped to 1
- rm  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- result  out  32  packed FP32
- flags  out  5  {NV,DZ,OF,UF,NX}; NV and DZ are always 0

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, flags=0. Reset mid-operation discards the in-flight bundle; IDLE is entered on the next edge.
- Handshake and capture:
  - IDLE: when in_valid&&in_ready, capture all inputs. Internal mantissa is 49 bits {carry,sum}; exponent is 10-bit signed. Go to NORM.
- NORM: one action per cycle.
  - Exact zero: if carry=0, sum=0 and sticky=0 → ROUND, zero path.
  - Carry set: if carry=1, shift right 1, OR the dropped bit into sticky, exp+1 → ROUND.
  - Coarse left shift: else if top SHIFT_STEP bits of sum are zero and exp>SHIFT_STEP, shift left SHIFT_STEP, exp-=SHIFT_STEP. Stay in NORM.
  - Single left shift: else if bit47=0 and exp>1, shift left 1, exp-1. Stay in NORM.
  - Otherwise (normalized, or exp==1 subnormal) → ROUND.
- ROUND (1 cycle):
  - Round bits: G=bit23, R=bit22, S=|bits21:0|sticky; inexact=G|R|S.
  - Increment rule:
    - RNE: G&(R|S|lsb)
    - RTZ: 0
    - RDN: inexact&sign
    - RUP: inexact&~sign
    - RMM: G
  - Increment carry-out renormalizes: mantissa=1.0, exp+1.
  - Biased exponent field = 0 when bit47=0 (subnormal).
  - UF = tiny (post-round bit47=0) & inexact.
  - Overflow: exp>=255 → OF=NX=1. Result is Inf when rm is RNE/RMM, or RUP&~sign, or RDN&sign; otherwise 0x7F7FFFFF with sign.
  - Zero path: sign = eff_sub ? (rm==RDN) : sign_res; flags=0.
  - Register result and flags → DONE.
- DONE: out_valid=1; result and flags held stable until out_ready. On out_valid&&out_ready → IDLE (out_valid=0, in_ready=1). No accept in the same cycle.
- Latency: accept at edge E0. Let k = number of NORM cycles (k≥1). out_valid rises after edge E0+k+1. Minimum 2 cycles.

Optional Feature:
- FP_NORM_LZC_EN
  - Defined: a 48-bit leading-zero counter performs the full normalize in one NORM cycle, shift = min(lzc, exp-1), so k=1 always.
  - Undefined: iterative stepping as above; the SHIFT_STEP parameter is used only in this mode.
  - Results and flags are identical in both modes.

Test Plan:
- 1.0+1.0: carry=1, sum=0, exp_in=127, eff_sub=0, RNE → result 0x40000000, flags 0, out_valid 2 cycles after accept.
- Cancellation: sum=48'h0100_0000_0000 (7 leading zeros), exp_in=127, eff_sub=1 → result 0x3C000000; k=5 (4,1,1,1 shifts + check); with FP_NORM_LZC_EN, k=1.
- Exact zero: sum=0, carry=0, sticky=0, eff_sub=1 → RNE 0x00000000; RDN 0x80000000; flags 0.
- Overflow: exp_in=254, carry=1, sign=0 → RNE 0x7F800000 flags OF|NX; RTZ 0x7F7FFFFF flags OF|NX.
- Tie: sum={1'b1,23'h0,1'b1,23'h0}, sticky=0, exp_in=127 → RNE 0x3F800000 NX; RUP 0x3F800001 NX; RMM 0x3F800001 NX.
- Backpressure/reset: out_ready low 5 cycles → result/flags stable, in_ready=0. Reset asserted during NORM → next cycle state IDLE, in_ready=1, out_valid=0.
